ex_muldiv_unit: RTL

Parametrised multi-cycle multiply/divide unit in the execute stage, beside the single-cycle ALU. It takes the instruction's operands through the same EX/MEM and MEM/WB forwarding selects the ALU uses. It runs an iterative shift-add multiply or restoring divide, and stalls the front of the pipeline until the result is ready. It produces one result per accepted instruction into the EX/MEM result mux, and it can be cancelled by a pipeline flush.

---
 rtl/ex_muldiv_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the execute stage: shift-add multiply,
// restoring divide, UNROLL iterations per clock, pipeline stall while busy.
module ex_muldiv_unit #(
   parameter int WIDTH  = 16,
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [1:0]       fwd_a,
   input  logic [1:0]       fwd_b,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic [WIDTH-1:0] exmem_data,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero
);

   localparam int N     = WIDTH / UNROLL;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   m_q, hi_q, lo_q;
   logic [WIDTH-1:0]   hi_nx, lo_nx, a_sel, b_sel, res_c;
   logic [2*WIDTH-1:0] acc_c;
   logic               accept, last;

   // One iteration. Multiply: {hi,lo} holds partial product over the shifting
   // multiplier. Divide: hi is the partial remainder, lo the dividend turning
   // into the quotient. The extra diff bit keeps B==0 on the subtract path.
   function automatic logic [2*WIDTH-1:0] step(input logic is_div,
                                               input logic [WIDTH-1:0] hi,
                                               input logic [WIDTH-1:0] lo,
                                               input logic [WIDTH-1:0] m);
      logic [WIDTH:0]   sum;
      logic [WIDTH:0]   t;
      logic [WIDTH+1:0] diff;
      sum  = '0;
      t    = '0;
      diff = '0;
      if (!is_div) begin
         sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
         step = {sum, lo[WIDTH-1:1]};
      end else begin
         t    = {hi, lo[WIDTH-1]};
         diff = {1'b0, t} - {2'b00, m};
         if (!diff[WIDTH+1])
            step = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
         else
            step = {t[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      end
   endfunction

   always_comb begin
      case (fwd_a)
         2'b01:   a_sel = exmem_data;
         2'b10:   a_sel = wb_data;
         default: a_sel = rs_data;
      endcase
      case (fwd_b)
         2'b01:   b_sel = exmem_data;
         2'b10:   b_sel = wb_data;
         default: b_sel = rt_data;
      endcase
   end

   always_comb begin
      acc_c = {hi_q, lo_q};
      for (int i = 0; i < UNROLL; i++)
         acc_c = step(op_q[1], acc_c[2*WIDTH-1:WIDTH], acc_c[WIDTH-1:0], m_q);
      hi_nx = acc_c[2*WIDTH-1:WIDTH];
      lo_nx = acc_c[WIDTH-1:0];
      // MULHU and REMU live in the upper half, MUL and DIVU in the lower half
      res_c = op_q[0] ? hi_nx : lo_nx;
   end

   assign accept = (state == IDLE) && start && !flush;
   assign last   = (cnt == CNT_W'(N - 1));
   assign stall  = !rst && (accept || ((state == RUN) && !flush));
   assign done   = (state == DONE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (flush) state_nx = IDLE;
                  else if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept)
            cnt <= '0;
         else if (state == RUN)
            cnt <= cnt + CNT_W'(1);
         if ((state == RUN) && last && !flush) begin
            result      <= res_c;
            div_by_zero <= op_q[1] && (m_q == '0);
         end
      end
   end

   // Operand/working registers carry no reset; they are loaded on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q <= op;
         m_q  <= op[1] ? b_sel : a_sel;
         hi_q <= '0;
         lo_q <= op[1] ? a_sel : b_sel;
      end else if (state == RUN) begin
         hi_q <= hi_nx;
         lo_q <= lo_nx;
      end
   end

endmodule
